// File: rtl/sr_hypot_unit.sv
// sr_hypot_unit: iterative y=floor(sqrt(a*a+b*b)); in clk/rst/start/a/b, out y (W+1 bits), busy, one-cycle done
module sr_hypot_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   y,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, SQA, SQB, ROOT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, op;
  logic [2*W:0] acc_q, acc_d, add;
  logic [W:0] root_q, root_d, y_q, y_d, trial;
  logic [2*W+1:0] sq;
  logic done_q, done_d, last, fit;
  assign last  = cnt_q == CW'(W - 1);
  assign op    = state_q == SQB ? b_q : a_q;
  assign add   = op[cnt_q[$clog2(W)-1:0]] ? (2*W+1)'(op) << cnt_q : '0;
  assign trial = root_q | ((W+1)'(1) << cnt_q);
  assign sq    = (2*W+2)'(trial) * (2*W+2)'(trial);
  assign fit   = sq <= (2*W+2)'(acc_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      root_q  <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      root_q  <= root_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SQA : IDLE;
      SQA:     state_d = last ? SQB : SQA;
      SQB:     state_d = last ? ROOT : SQB;
      ROOT:    state_d = cnt_q == '0 ? IDLE : ROOT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    root_d = root_q;
    y_d    = y_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        a_d    = a;
        b_d    = b;
        acc_d  = '0;
        root_d = '0;
        cnt_d  = '0;
      end
      SQA, SQB: begin
        acc_d = acc_q + add;
        cnt_d = last ? (state_q == SQB ? CW'(W) : '0) : cnt_q + 1'b1;
      end
      ROOT: begin
        root_d = fit ? trial : root_q;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d  = '0;
          y_d    = root_d;
          done_d = 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end
  always_comb busy = state_q != IDLE;
  assign y    = y_q;
  assign done = done_q;
endmodule
